// File: rtl/bp_weight_sched.sv
// bp_weight_sched: walks all output-neuron weights through one shared
// backprop unit over a req/done handshake and keeps the updated weight bank.
// Ports: clk_i/rst_i (async, active low), en_i freeze, init_i/start_i
// control, hidden_i flat hidden values, bp_req_o/bp_done_i/bp_w_i backprop
// handshake, idx_o/hidden_sel_o/w_cur_o current operands, weights_o flat
// bank, busy_o, b_end_o pass-complete pulse, err_o sticky timeout flag.
// Option macro: SKIP_ZERO_HIDDEN_EN skips indices whose hidden value is 0.
module bp_weight_sched #(
  parameter int N_WEIGHTS = 8,
  parameter int W_WIDTH   = 8,
  parameter int H_WIDTH   = 10,
  parameter int TIMEOUT   = 16,
  localparam int IW = (N_WEIGHTS > 1) ? $clog2(N_WEIGHTS) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         en_i,
  input  logic                         init_i,
  input  logic                         start_i,
  input  logic [N_WEIGHTS*H_WIDTH-1:0] hidden_i,
  output logic                         bp_req_o,
  input  logic                         bp_done_i,
  input  logic [W_WIDTH-1:0]           bp_w_i,
  output logic [IW-1:0]                idx_o,
  output logic [H_WIDTH-1:0]           hidden_sel_o,
  output logic [W_WIDTH-1:0]           w_cur_o,
  output logic [N_WEIGHTS*W_WIDTH-1:0] weights_o,
  output logic                         busy_o,
  output logic                         b_end_o,
  output logic                         err_o
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [IW-1:0] IDX_LAST = IW'(N_WEIGHTS - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);

  logic [1:0]         state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               err_q, err_d;
  logic [W_WIDTH-1:0] w_q [N_WEIGHTS];
  logic [W_WIDTH-1:0] w_d [N_WEIGHTS];

  logic [H_WIDTH-1:0] h_sel;
  logic [W_WIDTH-1:0] w_sel;
  logic               last_idx;

  always_comb begin
    h_sel = '0;
    w_sel = '0;
    for (int k = 0; k < N_WEIGHTS; k++) begin
      if (idx_q == IW'(k)) begin
        h_sel = hidden_i[k*H_WIDTH +: H_WIDTH];
        w_sel = w_q[k];
      end
    end
  end

  always_comb begin
    weights_o = '0;
    for (int k = 0; k < N_WEIGHTS; k++) begin
      weights_o[k*W_WIDTH +: W_WIDTH] = w_q[k];
    end
  end

  assign last_idx     = (idx_q == IDX_LAST);
  assign idx_o        = idx_q;
  assign hidden_sel_o = h_sel;
  assign w_cur_o      = w_sel;
  assign busy_o       = (state_q != S_IDLE);
  assign b_end_o      = (state_q == S_DONE);
  assign err_o        = err_q;

`ifdef SKIP_ZERO_HIDDEN_EN
  assign bp_req_o = (state_q == S_WAIT) ||
                    ((state_q == S_ISSUE) && (h_sel != '0));
`else
  assign bp_req_o = (state_q == S_WAIT) || (state_q == S_ISSUE);
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    err_d   = err_q;
    for (int k = 0; k < N_WEIGHTS; k++) begin
      w_d[k] = w_q[k];
    end
    unique case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (init_i) begin
          for (int k = 0; k < N_WEIGHTS; k++) begin
            w_d[k] = W_WIDTH'(k + 1);
          end
        end
        if (start_i) begin
          state_d = S_ISSUE;
          err_d   = 1'b0;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
`ifdef SKIP_ZERO_HIDDEN_EN
        // Zero activation means a zero gradient: skip the round trip.
        if (h_sel == '0) begin
          if (last_idx) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            idx_d   = idx_q + 1'b1;
          end
        end
`endif
      end
      S_WAIT: begin
        if (bp_done_i || (timer_q == T_LAST)) begin
          // Done takes priority over a coinciding timeout.
          if (bp_done_i) begin
            w_d[idx_q] = bp_w_i;
          end else begin
            err_d = 1'b1;
          end
          if (last_idx) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            idx_d   = idx_q + 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
      for (int k = 0; k < N_WEIGHTS; k++) begin
        w_q[k] <= '0;
      end
    end else if (en_i) begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      for (int k = 0; k < N_WEIGHTS; k++) begin
        w_q[k] <= w_d[k];
      end
    end
  end

endmodule

// File: tb/tb_bp_weight_sched.sv
// tb_bp_weight_sched: scoreboard bench for bp_weight_sched.
// Drives passes with a scripted backprop responder and checks timing/weights.
module tb_bp_weight_sched;

  localparam int N  = 8;
  localparam int WW = 8;
  localparam int HW = 10;
  localparam int TO = 16;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en_i;
  logic          init_i;
  logic          start_i;
  logic [N*HW-1:0] hidden_i;
  logic          bp_req_o;
  logic          bp_done_i;
  logic [WW-1:0] bp_w_i;
  logic [IW-1:0] idx_o;
  logic [HW-1:0] hidden_sel_o;
  logic [WW-1:0] w_cur_o;
  logic [N*WW-1:0] weights_o;
  logic          busy_o;
  logic          b_end_o;
  logic          err_o;

  bp_weight_sched #(
    .N_WEIGHTS(N), .W_WIDTH(WW), .H_WIDTH(HW), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst_n), .en_i(en_i),
    .init_i(init_i), .start_i(start_i), .hidden_i(hidden_i),
    .bp_req_o(bp_req_o), .bp_done_i(bp_done_i), .bp_w_i(bp_w_i),
    .idx_o(idx_o), .hidden_sel_o(hidden_sel_o), .w_cur_o(w_cur_o),
    .weights_o(weights_o), .busy_o(busy_o), .b_end_o(b_end_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [WW-1:0] model [N];
  logic [HW-1:0] h [N];
  int            resp [N];
  int            req_q [$];
  int            end_q [$];

  always_comb begin
    hidden_i = '0;
    for (int k = 0; k < N; k++) hidden_i[k*HW +: HW] = h[k];
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N*WW-1:0] pack_w();
    logic [N*WW-1:0] v;
    for (int k = 0; k < N; k++) v[k*WW +: WW] = model[k];
    return v;
  endfunction

  task automatic close_req(input int cnt);
    if (req_q.size() > 0) chk("req_len", 64'(cnt), 64'(req_q.pop_front()));
    else chk("req_extra", 64'd1, 64'd0);
  endtask

  task automatic run_pass(input bit poke);
    int cyc, cnt, cur, tot;
    bit inr, ended, exp_err;
    tot = 1; exp_err = 0;
    for (int k = 0; k < N; k++) begin
`ifdef SKIP_ZERO_HIDDEN_EN
      if (h[k] == '0) begin
        tot += 1;
        continue;
      end
`endif
      if (resp[k] == 0) begin
        req_q.push_back(1 + TO);
        tot += 1 + TO;
        exp_err = 1;
      end else begin
        req_q.push_back(1 + resp[k]);
        tot += 1 + resp[k];
      end
    end
    end_q.push_back(tot);
    start_i = 1'b1;
    cyc = 0; cnt = 0; cur = 0; inr = 0; ended = 0;
    while (!ended && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      start_i = 1'b0; init_i = 1'b0; bp_done_i = 1'b0;
      if (cyc == 1) chk("err_clr", 64'(err_o), 64'd0);
      if (poke && cyc == 5) begin
        start_i = 1'b1;
        init_i  = 1'b1;
      end
      if (bp_req_o) begin
        if (!inr || int'(idx_o) != cur) begin
          if (inr) close_req(cnt);
          inr = 1; cur = int'(idx_o); cnt = 0;
          chk("w_cur", 64'(w_cur_o), 64'(model[cur]));
          chk("h_sel", 64'(hidden_sel_o), 64'(h[cur]));
        end
        cnt++;
        if (resp[cur] != 0 && cnt - 1 == resp[cur]) begin
          bp_done_i  = 1'b1;
          bp_w_i     = model[cur] + 8'd16;
          model[cur] = model[cur] + 8'd16;
        end
      end else if (inr) begin
        close_req(cnt);
        inr = 0;
      end
      if (b_end_o) begin
        ended = 1;
        chk("b_end_cyc", 64'(cyc), 64'(end_q.pop_front()));
      end
    end
    if (!ended) chk("b_end_seen", 64'd0, 64'd1);
    @(posedge clk); #1;
    chk("idle_busy", 64'(busy_o), 64'd0);
    chk("idle_b_end", 64'(b_end_o), 64'd0);
    chk("weights", 64'(weights_o), 64'(pack_w()));
    chk("err", 64'(err_o), 64'(exp_err));
    chk("req_q_left", 64'(req_q.size()), 64'd0);
    req_q.delete();
    end_q.delete();
  endtask

  initial begin
    int n_end;
    rst_n = 1'b0; en_i = 1'b1; init_i = 1'b0; start_i = 1'b0;
    bp_done_i = 1'b0; bp_w_i = '0;
    for (int k = 0; k < N; k++) begin
      model[k] = '0;
      h[k] = HW'(k * 37 + 5);
      resp[k] = 1;
    end
    #12;
    chk("rst_weights", 64'(weights_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_req", 64'(bp_req_o), 64'd0);
    chk("rst_b_end", 64'(b_end_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_idx", 64'(idx_o), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    init_i = 1'b1;
    @(posedge clk); #1;
    init_i = 1'b0;
    for (int k = 0; k < N; k++) model[k] = WW'(k + 1);
    chk("init_weights", 64'(weights_o), 64'h0807060504030201);
    chk("init_busy", 64'(busy_o), 64'd0);

    run_pass(1'b0);
    chk("pass1_w", 64'(weights_o), 64'h1817161514131211);

    en_i = 1'b0; init_i = 1'b1;
    @(posedge clk); #1;
    en_i = 1'b1; init_i = 1'b0;
    chk("en_freeze", 64'(weights_o), 64'(pack_w()));

    resp[3] = 0;
    run_pass(1'b0);
    resp[3] = 1;

    resp[5] = TO;
    run_pass(1'b1);
    resp[5] = 1;

    start_i = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < N; k++) model[k] = '0;
    chk("mid_rst_w", 64'(weights_o), 64'd0);
    chk("mid_rst_busy", 64'(busy_o), 64'd0);
    chk("mid_rst_req", 64'(bp_req_o), 64'd0);
    chk("mid_rst_err", 64'(err_o), 64'd0);
    #1 rst_n = 1'b1;
    n_end = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (b_end_o || busy_o) n_end++;
    end
    chk("no_b_end", 64'(n_end), 64'd0);

`ifdef SKIP_ZERO_HIDDEN_EN
    h[2] = '0;
    h[6] = '0;
    run_pass(1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
